// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and constants for the FIFO write-port arbiter
package fifo_arb_pkg;
  typedef enum logic [1:0] {IDLE, XFER, DROP} arb_state_t;
  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;
  localparam int MAX_FRAME_LEN_DEF = 1518;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-requester round-robin grant, ties go to the port not granted last
module rr_arbiter2
  import fifo_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);
  // a lone requester wins outright; on a tie the other port gets its turn
  always_comb gnt = &req ? (last_grant == PORT0 ? 2'b10 : 2'b01) : req;
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: frame-atomic round-robin sharing of a FIFO write port between two byte streams
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int MAX_FRAME_LEN = MAX_FRAME_LEN_DEF,
  parameter int CNT_WIDTH     = 11
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
  input  logic                  s0_axis_tvalid,
  input  logic                  s0_axis_tlast,
  output logic                  s0_axis_tready,
  input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
  input  logic                  s1_axis_tvalid,
  input  logic                  s1_axis_tlast,
  output logic                  s1_axis_tready,
  output logic [DATA_WIDTH:0]   fifo_wr_data,
  output logic                  fifo_wr_en,
  input  logic                  fifo_full,
  input  logic                  fifo_almost_full,
  output logic [1:0]            grant,
  output logic                  frame_trunc
);
  arb_state_t            state_q, state_d;
  logic [1:0]            grant_q, grant_d, req, arb_gnt;
  logic [CNT_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
  logic                  last_grant_q, last_grant_d, frame_trunc_q, frame_trunc_d;
  logic                  sel, tvalid, tlast, rdy, acc, at_max;
  logic [DATA_WIDTH-1:0] tdata;

  assign req = {s1_axis_tvalid, s0_axis_tvalid};

  rr_arbiter2 u_arb (.req(req), .last_grant(last_grant_q), .gnt(arb_gnt));

  // mux the granted source and derive handshake / write strobe
  always_comb begin
    sel            = grant_q[1];
    tvalid         = sel ? s1_axis_tvalid : s0_axis_tvalid;
    tlast          = sel ? s1_axis_tlast : s0_axis_tlast;
    tdata          = sel ? s1_axis_tdata : s0_axis_tdata;
    rdy            = state_q == XFER ? !fifo_full : state_q == DROP;
    s0_axis_tready = grant_q[0] & rdy;
    s1_axis_tready = grant_q[1] & rdy;
    acc            = (|grant_q) & tvalid & rdy;
    at_max         = beat_cnt_q == CNT_WIDTH'(MAX_FRAME_LEN - 1);
    fifo_wr_en     = acc & (state_q == XFER);
    fifo_wr_data   = fifo_wr_en ? {tlast | at_max, tdata} : '0;
  end

  // next-state: arbitrate in IDLE, count beats in XFER, truncate into DROP, release on tlast
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    beat_cnt_d    = beat_cnt_q;
    last_grant_d  = last_grant_q;
    frame_trunc_d = 1'b0;
    case (state_q)
      IDLE: if (!fifo_almost_full && |req) begin
        grant_d = arb_gnt;
        state_d = XFER;
      end
      XFER: if (acc && !tlast) begin
        if (at_max) begin
          state_d       = DROP;
          frame_trunc_d = 1'b1;
        end else beat_cnt_d = beat_cnt_q + CNT_WIDTH'(1);
      end
      DROP: ;
      default: state_d = IDLE;
    endcase
    if (acc && tlast) begin
      state_d      = IDLE;
      grant_d      = 2'b00;
      beat_cnt_d   = '0;
      last_grant_d = sel;
    end
  end

  // state registers; port 1 marked as last owner so port 0 wins the first tie
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      grant_q       <= 2'b00;
      beat_cnt_q    <= '0;
      last_grant_q  <= PORT1;
      frame_trunc_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      beat_cnt_q    <= beat_cnt_d;
      last_grant_q  <= last_grant_d;
      frame_trunc_q <= frame_trunc_d;
    end
  end

  assign grant       = grant_q;
  assign frame_trunc = frame_trunc_q;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed self-checking bench for the FIFO write-port arbiter
module tb_fifo_wr_arbiter;
  logic       clk = 1'b0, reset_n = 1'b0;
  logic [7:0] s0_d = '0, s1_d = '0;
  logic       s0_v = 1'b0, s0_l = 1'b0, s1_v = 1'b0, s1_l = 1'b0;
  logic       s0_r, s1_r, wr_en, full = 1'b0, afull = 1'b0, trunc;
  logic [8:0] wr_data;
  logic [1:0] grant;
  int         passed = 0, total = 0;

  fifo_wr_arbiter #(.DATA_WIDTH(8), .MAX_FRAME_LEN(4), .CNT_WIDTH(11)) dut (
    .clk(clk), .reset_n(reset_n),
    .s0_axis_tdata(s0_d), .s0_axis_tvalid(s0_v), .s0_axis_tlast(s0_l), .s0_axis_tready(s0_r),
    .s1_axis_tdata(s1_d), .s1_axis_tvalid(s1_v), .s1_axis_tlast(s1_l), .s1_axis_tready(s1_r),
    .fifo_wr_data(wr_data), .fifo_wr_en(wr_en), .fifo_full(full), .fifo_almost_full(afull),
    .grant(grant), .frame_trunc(trunc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic wr(input string tag, input logic [8:0] d);
    chk({tag, "_en"}, 32'(wr_en), 32'd1);
    chk({tag, "_data"}, 32'(wr_data), 32'(d));
  endtask

  initial begin
    #1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_rdy", 32'({s0_r, s1_r}), 32'd0);
    chk("rst_wren", 32'(wr_en), 32'd0);
    chk("rst_wdata", 32'(wr_data), 32'd0);
    chk("rst_trunc", 32'(trunc), 32'd0);
    nxt(); reset_n = 1'b1;
    // single frame from s0
    nxt(); s0_v = 1; s0_d = 8'hA0; #1;
    chk("s1_bubble_grant", 32'(grant), 32'd0);
    chk("s1_bubble_wren", 32'(wr_en), 32'd0);
    chk("s1_bubble_rdy", 32'(s0_r), 32'd0);
    nxt(); #1; wr("s1_b0", 9'h0A0); chk("s1_grant", 32'(grant), 32'd1);
    nxt(); s0_d = 8'hA1; #1; wr("s1_b1", 9'h0A1);
    nxt(); s0_d = 8'hA2; #1; wr("s1_b2", 9'h0A2);
    nxt(); s0_d = 8'hA3; s0_l = 1; #1; wr("s1_b3", 9'h1A3);
    nxt(); s0_v = 0; s0_l = 0; #1;
    chk("s1_after_grant", 32'(grant), 32'd0);
    chk("s1_after_wren", 32'(wr_en), 32'd0);
    // reset mid-frame
    nxt(); s0_v = 1; s0_d = 8'hB0; #1; chk("rm_idle", 32'(grant), 32'd0);
    nxt(); #1; wr("rm_b0", 9'h0B0);
    nxt(); s0_d = 8'hB1; #1; wr("rm_b1", 9'h0B1);
    nxt(); s0_d = 8'hB2; reset_n = 0; #1;
    chk("rm_grant", 32'(grant), 32'd0);
    chk("rm_rdy", 32'({s0_r, s1_r}), 32'd0);
    chk("rm_wren", 32'(wr_en), 32'd0);
    nxt(); reset_n = 1; s0_v = 0;
    // tie after reset: s0 first, then s1, no interleave
    nxt(); s0_v = 1; s0_d = 8'hC0; s1_v = 1; s1_d = 8'hD0; #1; chk("tie_idle", 32'(grant), 32'd0);
    nxt(); #1; wr("tie_c0", 9'h0C0); chk("tie_g0", 32'(grant), 32'd1); chk("tie_r1", 32'(s1_r), 32'd0);
    nxt(); s0_d = 8'hC1; #1; wr("tie_c1", 9'h0C1);
    nxt(); s0_d = 8'hC2; s0_l = 1; #1; wr("tie_c2", 9'h1C2); chk("tie_r1b", 32'(s1_r), 32'd0);
    nxt(); s0_v = 0; s0_l = 0; #1;
    chk("tie_bubble_grant", 32'(grant), 32'd0);
    chk("tie_bubble_wren", 32'(wr_en), 32'd0);
    nxt(); #1; wr("tie_d0", 9'h0D0); chk("tie_g1", 32'(grant), 32'd2); chk("tie_r0", 32'(s0_r), 32'd0);
    nxt(); s1_d = 8'hD1; #1; wr("tie_d1", 9'h0D1);
    nxt(); s1_d = 8'hD2; s1_l = 1; #1; wr("tie_d2", 9'h1D2);
    // second tie returns to s0
    nxt(); s0_v = 1; s0_d = 8'hE0; s0_l = 1; s1_d = 8'hF0; #1; chk("tie2_idle", 32'(grant), 32'd0);
    nxt(); #1; wr("tie2_e0", 9'h1E0); chk("tie2_g0", 32'(grant), 32'd1);
    nxt(); s0_v = 0; s0_l = 0; #1; chk("tie2_bubble", 32'(wr_en), 32'd0);
    nxt(); #1; wr("tie2_f0", 9'h1F0); chk("tie2_g1", 32'(grant), 32'd2);
    nxt(); s1_v = 0; s1_l = 0;
    // full stall for 3 cycles mid-frame
    nxt(); s0_v = 1; s0_d = 8'h10;
    nxt(); #1; wr("st_b0", 9'h010);
    nxt(); s0_d = 8'h11; #1; wr("st_b1", 9'h011);
    for (int i = 0; i < 3; i++) begin
      nxt(); s0_d = 8'h12; full = 1; #1;
      chk("st_rdy", 32'(s0_r), 32'd0);
      chk("st_wren", 32'(wr_en), 32'd0);
    end
    nxt(); full = 0; #1; wr("st_b2", 9'h012);
    nxt(); s0_d = 8'h13; s0_l = 1; #1; wr("st_b3", 9'h113);
    nxt(); s0_v = 0; s0_l = 0; #1; chk("st_done", 32'(grant), 32'd0);
    // almost-full holds off frame start
    nxt(); s1_v = 1; s1_d = 8'h20; s1_l = 1; afull = 1; #1; chk("af_g0", 32'(grant), 32'd0);
    nxt(); #1; chk("af_g1", 32'(grant), 32'd0); chk("af_rdy", 32'(s1_r), 32'd0);
    nxt(); #1; chk("af_g2", 32'(grant), 32'd0);
    nxt(); afull = 0; #1; chk("af_g3", 32'(grant), 32'd0);
    nxt(); #1; chk("af_grant", 32'(grant), 32'd2); wr("af_b0", 9'h120);
    nxt(); s1_v = 0; s1_l = 0;
    // truncation at 4 beats of a 7-beat frame
    nxt(); s0_v = 1; s0_d = 8'h30; #1; chk("tr_idle", 32'(grant), 32'd0);
    nxt(); #1; wr("tr_b0", 9'h030);
    nxt(); s0_d = 8'h31; #1; wr("tr_b1", 9'h031);
    nxt(); s0_d = 8'h32; #1; wr("tr_b2", 9'h032);
    nxt(); s0_d = 8'h33; #1; wr("tr_b3", 9'h133); chk("tr_pulse_early", 32'(trunc), 32'd0);
    nxt(); s0_d = 8'h34; #1;
    chk("tr_pulse", 32'(trunc), 32'd1); chk("tr_rdy4", 32'(s0_r), 32'd1); chk("tr_wren4", 32'(wr_en), 32'd0);
    nxt(); s0_d = 8'h35; #1;
    chk("tr_pulse_end", 32'(trunc), 32'd0); chk("tr_rdy5", 32'(s0_r), 32'd1); chk("tr_wren5", 32'(wr_en), 32'd0);
    nxt(); s0_d = 8'h36; s0_l = 1; #1; chk("tr_rdy6", 32'(s0_r), 32'd1); chk("tr_wren6", 32'(wr_en), 32'd0);
    nxt(); s0_v = 0; s0_l = 0; #1; chk("tr_done", 32'(grant), 32'd0); chk("tr_done_rdy", 32'(s0_r), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
